// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load-op encodings and bus layouts.
// Pure declarations, no latency.
// No flow control lives here.
package mem_stage_pkg;

    localparam int EX_TO_ME_W = 76;
    localparam int ME_TO_WB_W = 70;

    // EX_to_ME_Bus field offsets (LSB of each field)
    localparam int EM_ALU_RESULT_LSB = 0;
    localparam int EM_ADDR_LO_LSB    = 32;
    localparam int EM_LD_OP_LSB      = 34;
    localparam int EM_MEM_REQ_BIT    = 37;
    localparam int EM_DEST_LSB       = 38;
    localparam int EM_GR_WE_BIT      = 43;
    localparam int EM_PC_LSB         = 44;

    // ME_to_WB_Bus field offsets
    localparam int MW_RESULT_LSB = 0;
    localparam int MW_DEST_LSB   = 32;
    localparam int MW_GR_WE_BIT  = 37;
    localparam int MW_PC_LSB     = 38;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_H    = 3'd2,
        LD_W    = 3'd3,
        LD_BU   = 3'd4,
        LD_HU   = 3'd5
    } ld_op_e;

    // ld_op kept as raw bits so the reserved codes 6/7 stay representable
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_req;
        logic [2:0]  ld_op;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
    } ex_me_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } me_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction and sign/zero extension; reserved ld_op codes pass alu_result.
// Latency: combinational.
// No backpressure; pure function of its inputs.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_op,
    input  logic [31:0] alu_result,
    output logic [31:0] final_result
);

    logic [31:0] shifted;
    logic [7:0]  byte_dat;
    logic [15:0] half_dat;

    assign shifted  = word >> {addr_lo, 3'b000};
    assign byte_dat = shifted[7:0];
    assign half_dat = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        final_result = alu_result;
        case (ld_op)
            LD_B:    final_result = {{24{byte_dat[7]}}, byte_dat};
            LD_H:    final_result = {{16{half_dat[15]}}, half_dat};
            LD_W:    final_result = word;
            LD_BU:   final_result = {24'd0, byte_dat};
            LD_HU:   final_result = {16'd0, half_dat};
            default: final_result = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the data-SRAM response, aligns load data.
// Latency: 1 cycle for non-memory ops; memory ops leave in the data_ok cycle or later.
// Backpressure: held while WB_Allow_in is low or a response is pending; optional MEM_STAGE_PERF_CNT_EN adds perf_wait_cnt.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ME_Allow_in,
    input  logic                  EX_to_ME_Valid,
    input  logic [EX_TO_ME_W-1:0] EX_to_ME_Bus,
    input  logic                  data_sram_data_ok,
    input  logic [31:0]           data_sram_rdata,
    input  logic                  WB_Allow_in,
    output logic                  ME_to_WB_Valid,
    output logic [ME_TO_WB_W-1:0] ME_to_WB_Bus,
    output logic [4:0]            ME_dest,
`ifdef MEM_STAGE_PERF_CNT_EN
    output logic                  ME_load_busy,
    output logic [31:0]           perf_wait_cnt
`else
    output logic                  ME_load_busy
`endif
);

    ex_me_t      ex_in;
    ex_me_t      me_r;
    me_wb_t      wb_out;
    logic        me_valid;
    logic        data_got;
    logic [31:0] rdata_buf;
    logic [31:0] load_word;
    logic [31:0] final_result;
    logic        me_ready_go;
    logic        in_wait;

    assign ex_in = ex_me_t'(EX_to_ME_Bus);

    assign in_wait     = me_valid && me_r.mem_req && !data_got;
    assign me_ready_go = !me_r.mem_req || data_got || data_sram_data_ok;
    assign ME_Allow_in = !me_valid || (me_ready_go && WB_Allow_in);
    assign ME_to_WB_Valid = me_valid && me_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            me_valid <= 1'b0;
            me_r     <= '0;
        end else if (ME_Allow_in) begin
            me_valid <= EX_to_ME_Valid;
            if (EX_to_ME_Valid)
                me_r <= ex_in;
        end
    end

    // Any cycle the stage accepts (instruction leaving and/or entering) resets the response flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_got  <= 1'b0;
            rdata_buf <= '0;
        end else if (ME_Allow_in) begin
            data_got <= 1'b0;
        end else if (in_wait && data_sram_data_ok) begin
            data_got  <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    assign load_word = data_sram_data_ok ? data_sram_rdata : rdata_buf;

    load_align u_load_align (
        .word         (load_word),
        .addr_lo      (me_r.addr_lo),
        .ld_op        (me_r.ld_op),
        .alu_result   (me_r.alu_result),
        .final_result (final_result)
    );

    always_comb begin
        wb_out.pc           = me_r.pc;
        wb_out.gr_we        = me_r.gr_we;
        wb_out.dest         = me_r.dest;
        wb_out.final_result = final_result;
    end

    assign ME_to_WB_Bus = wb_out;
    assign ME_dest      = (me_valid && me_r.gr_we) ? me_r.dest : 5'd0;
    assign ME_load_busy = me_valid && me_r.gr_we && (me_r.ld_op != LD_NONE)
                          && !data_got && !data_sram_data_ok;

`ifdef MEM_STAGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            perf_wait_cnt <= '0;
        else if (in_wait && perf_wait_cnt != 32'hFFFF_FFFF)
            perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ME_Allow_in;
    logic        EX_to_ME_Valid;
    logic [75:0] EX_to_ME_Bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        WB_Allow_in;
    logic        ME_to_WB_Valid;
    logic [69:0] ME_to_WB_Bus;
    logic [4:0]  ME_dest;
    logic        ME_load_busy;
`ifdef MEM_STAGE_PERF_CNT_EN
    logic [31:0] perf_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ME_Allow_in       (ME_Allow_in),
        .EX_to_ME_Valid    (EX_to_ME_Valid),
        .EX_to_ME_Bus      (EX_to_ME_Bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .WB_Allow_in       (WB_Allow_in),
        .ME_to_WB_Valid    (ME_to_WB_Valid),
        .ME_to_WB_Bus      (ME_to_WB_Bus),
        .ME_dest           (ME_dest),
`ifdef MEM_STAGE_PERF_CNT_EN
        .ME_load_busy      (ME_load_busy),
        .perf_wait_cnt     (perf_wait_cnt)
`else
        .ME_load_busy      (ME_load_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] exb(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                        input logic mreq, input logic [2:0] op, input logic [1:0] alo,
                                        input logic [31:0] alu);
        return {pc, we, dest, mreq, op, alo, alu};
    endfunction

    function automatic logic [69:0] wbb(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                        input logic [31:0] res);
        return {pc, we, dest, res};
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        EX_to_ME_Valid = 1'b0;
        EX_to_ME_Bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        WB_Allow_in = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_allow", 76'(ME_Allow_in), 76'd1);
        chk("rst_valid", 76'(ME_to_WB_Valid), 76'd0);
        chk("rst_dest", 76'(ME_dest), 76'd0);
        chk("rst_busy", 76'(ME_load_busy), 76'd0);
        chk("rst_bus", 76'(ME_to_WB_Bus), 76'd0);
`ifdef MEM_STAGE_PERF_CNT_EN
        chk("rst_perf", 76'(perf_wait_cnt), 76'd0);
`endif
        reset = 1'b0;

        // ALU op, 1-cycle latency
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000000, 1'b1, 5'd5, 1'b0, 3'd0, 2'd0, 32'h12345678);
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        chk("alu_valid", 76'(ME_to_WB_Valid), 76'd1);
        chk("alu_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000000, 1'b1, 5'd5, 32'h12345678)));
        chk("alu_dest", 76'(ME_dest), 76'd5);
        tick();
        chk("alu_drain", 76'(ME_to_WB_Valid), 76'd0);

        // LD_B, addr_lo=3, response two cycles late
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000004, 1'b1, 5'd7, 1'b1, 3'd1, 2'd3, 32'h10000003);
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        chk("ldb_wait_allow", 76'(ME_Allow_in), 76'd0);
        chk("ldb_wait_busy", 76'(ME_load_busy), 76'd1);
        chk("ldb_wait_valid", 76'(ME_to_WB_Valid), 76'd0);
        chk("ldb_wait_dest", 76'(ME_dest), 76'd7);
        tick();
        tick();
        chk("ldb_wait2_busy", 76'(ME_load_busy), 76'd1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF7F01;
        settle();
        chk("ldb_ok_valid", 76'(ME_to_WB_Valid), 76'd1);
        chk("ldb_ok_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000004, 1'b1, 5'd7, 32'hFFFFFF80)));
        chk("ldb_ok_busy", 76'(ME_load_busy), 76'd0);
        chk("ldb_ok_allow", 76'(ME_Allow_in), 76'd1);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("ldb_drain", 76'(ME_to_WB_Valid), 76'd0);

        // Same load as LD_BU
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000008, 1'b1, 5'd7, 1'b1, 3'd4, 2'd3, 32'h10000003);
        tick();
        EX_to_ME_Valid = 1'b0;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF7F01;
        settle();
        chk("ldbu_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000008, 1'b1, 5'd7, 32'h00000080)));
        tick();
        data_sram_data_ok = 1'b0;

        // LD_HU, response while WB stalled for 3 cycles
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c00000c, 1'b1, 5'd9, 1'b1, 3'd5, 2'd2, 32'h10000002);
        tick();
        EX_to_ME_Valid = 1'b0;
        WB_Allow_in = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF0000;
        settle();
        chk("ldhu_ok_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c00000c, 1'b1, 5'd9, 32'h0000BEEF)));
        chk("ldhu_ok_allow", 76'(ME_Allow_in), 76'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("ldhu_hold_valid", 76'(ME_to_WB_Valid), 76'd1);
            chk("ldhu_hold_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c00000c, 1'b1, 5'd9, 32'h0000BEEF)));
            chk("ldhu_hold_busy", 76'(ME_load_busy), 76'd0);
            chk("ldhu_hold_allow", 76'(ME_Allow_in), 76'd0);
            tick();
        end
        WB_Allow_in = 1'b1;
        settle();
        chk("ldhu_acc_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c00000c, 1'b1, 5'd9, 32'h0000BEEF)));
        chk("ldhu_acc_allow", 76'(ME_Allow_in), 76'd1);
        tick();
        chk("ldhu_drain", 76'(ME_to_WB_Valid), 76'd0);

        // Back-to-back ALU ops, WB_Allow_in 1,0,1
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000100, 1'b1, 5'd1, 1'b0, 3'd0, 2'd0, 32'h000000A1);
        tick();
        EX_to_ME_Bus = exb(32'h1c000104, 1'b1, 5'd2, 1'b0, 3'd0, 2'd0, 32'h000000B2);
        settle();
        chk("b2b_a", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000100, 1'b1, 5'd1, 32'h000000A1)));
        tick();
        EX_to_ME_Bus = exb(32'h1c000108, 1'b1, 5'd3, 1'b0, 3'd0, 2'd0, 32'h000000C3);
        WB_Allow_in = 1'b0;
        settle();
        chk("b2b_b", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000104, 1'b1, 5'd2, 32'h000000B2)));
        chk("b2b_stall_allow", 76'(ME_Allow_in), 76'd0);
        tick();
        WB_Allow_in = 1'b1;
        settle();
        chk("b2b_b_held", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000104, 1'b1, 5'd2, 32'h000000B2)));
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        chk("b2b_c", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000108, 1'b1, 5'd3, 32'h000000C3)));
        chk("b2b_c_valid", 76'(ME_to_WB_Valid), 76'd1);
        tick();
        chk("b2b_drain", 76'(ME_to_WB_Valid), 76'd0);

        // Spurious data_ok while empty, then a store
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h00000055;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("spur_valid", 76'(ME_to_WB_Valid), 76'd0);
        chk("spur_allow", 76'(ME_Allow_in), 76'd1);
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000200, 1'b0, 5'd3, 1'b1, 3'd0, 2'd0, 32'h0000ABCD);
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        chk("st_wait_valid", 76'(ME_to_WB_Valid), 76'd0);
        chk("st_wait_allow", 76'(ME_Allow_in), 76'd0);
        chk("st_wait_busy", 76'(ME_load_busy), 76'd0);
        data_sram_data_ok = 1'b1;
        settle();
        chk("st_ok_valid", 76'(ME_to_WB_Valid), 76'd1);
        chk("st_ok_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000200, 1'b0, 5'd3, 32'h0000ABCD)));
        chk("st_ok_dest", 76'(ME_dest), 76'd0);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("st_drain", 76'(ME_to_WB_Valid), 76'd0);

        // Reset during WAIT, then a late response
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000300, 1'b1, 5'd4, 1'b1, 3'd3, 2'd0, 32'h10000000);
        tick();
        EX_to_ME_Valid = 1'b0;
        settle();
        chk("rw_busy", 76'(ME_load_busy), 76'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rw_valid", 76'(ME_to_WB_Valid), 76'd0);
        chk("rw_allow", 76'(ME_Allow_in), 76'd1);
`ifdef MEM_STAGE_PERF_CNT_EN
        chk("rw_perf", 76'(perf_wait_cnt), 76'd0);
`endif
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h11112222;
        settle();
        chk("rw_late_valid", 76'(ME_to_WB_Valid), 76'd0);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("rw_late_valid2", 76'(ME_to_WB_Valid), 76'd0);
        chk("rw_late_busy", 76'(ME_load_busy), 76'd0);

`ifdef MEM_STAGE_PERF_CNT_EN
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus = exb(32'h1c000400, 1'b1, 5'd6, 1'b1, 3'd3, 2'd0, 32'h10000000);
        tick();
        EX_to_ME_Valid = 1'b0;
        tick();
        tick();
        chk("perf_cnt2", 76'(perf_wait_cnt), 76'd2);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFEF00D;
        settle();
        chk("perf_ldw_bus", 76'(ME_to_WB_Bus), 76'(wbb(32'h1c000400, 1'b1, 5'd6, 32'hCAFEF00D)));
        tick();
        data_sram_data_ok = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage LoongArch core, sitting between the execute stage and the write-back stage. It accepts one instruction per handshake from execute and waits for the data-SRAM response when execute issued a memory request. It extracts and extends load data and drives the 70-bit `ME_to_WB_Bus` consumed by write-back, plus hazard information for decode.

## Interface
Parameters: none.

Ports:
- `clk` in 1: core clock. One clock domain; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `ME_Allow_in` out 1: stage can accept a new instruction this cycle.
- `EX_to_ME_Valid` in 1: execute offers an instruction.
- `EX_to_ME_Bus` in 76, packed as:
  - `{pc[75:44], gr_we[43], dest[42:38], mem_req[37], ld_op[36:34], addr_lo[33:32], alu_result[31:0]}`
- `data_sram_data_ok` in 1: one-cycle pulse; response for the single outstanding request.
- `data_sram_rdata` in 32: load data, valid when `data_sram_data_ok` is high.
- `WB_Allow_in` in 1: write-back can accept.
- `ME_to_WB_Valid` out 1: stage holds a finished instruction.
- `ME_to_WB_Bus` out 70, packed as:
  - `{pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}`
- `ME_dest` out 5: `dest` gated by stage valid and `gr_we`; 0 otherwise.
- `ME_load_busy` out 1: valid load whose result is not yet available (decode stalls on a match).

## Operation
`ld_op` encoding:
- 0 = NONE: result is `alu_result`.
- 1 = LD_B, 2 = LD_H, 3 = LD_W, 4 = LD_BU, 5 = LD_HU.
- 6–7 = reserved; treated as NONE.
- A store has `mem_req=1`, `ld_op=0`, `gr_we=0`.

Pipeline register:
- Loaded when `EX_to_ME_Valid && ME_Allow_in`.
- `ME_Valid` takes the value of `EX_to_ME_Valid` whenever `ME_Allow_in` is high.

Response tracking, with per-instruction states derived from `ME_Valid`, `mem_req` and flag `data_got`:
- EMPTY: `ME_Valid=0`.
- WAIT: valid, `mem_req=1`, `data_got=0`.
- READY: valid, and either `mem_req=0` or `data_got=1`.

Transitions:
- WAIT→READY: on `data_sram_data_ok`. `data_sram_rdata` is latched into 32-bit `rdata_buf` and `data_got` is set.
- Instruction leaves: when `ME_to_WB_Valid && WB_Allow_in`, `data_got` clears.
- New instruction enters in the same cycle: `data_got` is forced to 0 for the incoming instruction.

Handshake signals:
- `ME_ReadyGo = !mem_req || data_got || data_sram_data_ok`.
- `ME_Allow_in = !ME_Valid || (ME_ReadyGo && WB_Allow_in)`.
- `ME_to_WB_Valid = ME_Valid && ME_ReadyGo`.

Load data:
- Source word is `data_sram_data_ok ? data_sram_rdata : rdata_buf`. Data arriving in the same cycle bypasses the buffer.
- Byte = word >> (`addr_lo`×8). Half = `addr_lo[1]` ? word[31:16] : word[15:0].
- Sign-extend for LD_B/LD_H; zero-extend for LD_BU/LD_HU.
- Alignment is not checked here; execute guarantees it.

Hazard outputs:
- `ME_load_busy = ME_Valid && gr_we && ld_op!=0 && !data_got && !data_sram_data_ok`.

Boundary conditions:
- `data_sram_data_ok` while EMPTY, while READY, or while `mem_req=0`: ignored. No state change.
- `data_ok` and `WB_Allow_in` in the same cycle: the instruction passes straight through with the bypassed data and `data_got` stays 0.
- `data_ok` while `WB_Allow_in=0`: data is buffered and the instruction is held. The bus stays stable until accepted.
- Reset during WAIT: the instruction is dropped. A response arriving after reset is ignored because the stage is EMPTY.

## Timing
- Non-memory instruction: latency 1 cycle (enters at edge N, presented to WB during cycle N+1). Throughput 1/cycle.
- Memory instruction: presented in the cycle `data_ok` arrives, or later. Minimum latency 1 cycle.
- `ME_to_WB_Bus` is combinational from the pipeline registers and `rdata_buf`/`data_sram_rdata`. There are no other combinational input-to-output paths except `WB_Allow_in`→`ME_Allow_in` and `data_ok`→ready/valid.
- Reset values:
  - `ME_Valid=0`, `data_got=0`.
  - All payload registers and `rdata_buf` = 0.
  - Hence `ME_Allow_in=1`, `ME_to_WB_Valid=0`, `ME_dest=0`, `ME_load_busy=0`, `ME_to_WB_Bus=0`.

## Configuration
- `MEM_STAGE_PERF_CNT_EN` defined:
  - Adds output `perf_wait_cnt` (32 bits).
  - Increments every cycle the stage is in WAIT, and saturates at 0xFFFFFFFF.
  - Cleared by reset.
- Undefined: the port and the counter logic do not exist. All other behaviour is identical.

## Structure
- Shared package holds:
  - `ld_op` encodings `LD_NONE`/`LD_B`/`LD_H`/`LD_W`/`LD_BU`/`LD_HU`.
  - Bus widths `EX_TO_ME_W=76` and `ME_TO_WB_W=70`.
  - Field offsets for both buses.
- One sub-module: `load_align`. It is combinational (word, `addr_lo`, `ld_op`, `alu_result`) → `final_result`, with the extraction and extension above.

## Test plan
- ALU op: pc=0x1c000000, `gr_we`=1, `dest`=5, `alu_result`=0x12345678, `WB_Allow_in`=1 → next cycle `ME_to_WB_Bus`={0x1c000000, 1, 5, 0x12345678}, `ME_dest`=5.
- LD_B with `addr_lo`=3, `rdata`=0x80FF7F01 returned with `data_ok` 2 cycles late:
  - While waiting: `ME_Allow_in`=0 and `ME_load_busy`=1.
  - On `data_ok`: `final_result`=0xFFFFFF80.
  - Same load as LD_BU → 0x00000080.
- LD_HU with `addr_lo`=2, `rdata`=0xBEEF0000, `data_ok` while `WB_Allow_in`=0 for 3 cycles → bus holds 0x0000BEEF stable, and it is accepted on the first `WB_Allow_in`=1.
- Back-to-back ALU ops with `WB_Allow_in` toggling 1,0,1 → no drop or duplicate; order preserved.
- Spurious `data_ok` while EMPTY, then a store whose `data_ok` arrives → store passes with `gr_we`=0 and `ME_dest`=0.
- Reset asserted during WAIT, then a late `data_ok` → `ME_to_WB_Valid` stays 0. With `MEM_STAGE_PERF_CNT_EN`, `perf_wait_cnt`=0 after reset.
